// File: rtl/rr_lock_arb_pkg.sv
// Shared sizing helpers for the round-robin lock arbiter and its search block.
package rr_lock_arb_pkg;

   // Width of a binary index into n requesters (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a hold counter that must reach maxhold-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned maxhold);
      return (maxhold > 1) ? $clog2(maxhold) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - highest-priority index; search runs ptr, ptr+1, ... modulo N
//   winner - one-hot first set request in search order, zero if req is zero
module rr_pick
   import rr_lock_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned W = idx_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] winner
);

   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] dbl_win;
   logic [N-1:0]   rot_req;
   logic [N-1:0]   rot_win;
   logic           found;

   // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      dbl_req = {req, req} >> ptr;
      rot_req = dbl_req[N-1:0];
      rot_win = '0;
      found   = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (rot_req[i] && !found) begin
            rot_win[i] = 1'b1;
            found      = 1'b1;
         end
      end
      dbl_win = {rot_win, rot_win} << ptr;
      winner  = dbl_win[2*N-1:N];
   end

endmodule

// File: rtl/rr_lock_arb.sv
// rr_lock_arb: round-robin arbiter that locks a grant until the transaction
// completes, the requester aborts, or an optional hold limit expires.
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - asynchronous active-high reset
//   req         - request per requester, held until its transaction completes
//   done        - current transaction finished (ignored with no grant)
//   grant       - registered one-hot grant
//   grant_valid - high while grant is non-zero
//   grant_idx   - binary index of the granted requester, 0 with no grant
//   timeout     - one-cycle pulse when the hold limit forced a release
module rr_lock_arb
   import rr_lock_arb_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned MAXHOLD = 0,
   localparam int unsigned W      = idx_width(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx,
   output logic         timeout
);

   localparam int unsigned CW = cnt_width(MAXHOLD);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t        state;
   logic [W-1:0]  ptr;
   logic [CW-1:0] hold_cnt;

   logic [W-1:0]  ptr_after;
   logic [W-1:0]  pick_ptr;
   logic [N-1:0]  winner;
   logic [W-1:0]  win_idx;
   logic          req_held;
   logic          at_limit;
   logic          release_now;

   // Pointer that follows the current holder; used for the same-cycle re-search.
   assign ptr_after   = (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
   assign pick_ptr    = (state == HOLD) ? ptr_after : ptr;
   assign req_held    = |(req & grant);
   assign at_limit    = (MAXHOLD != 0) && (hold_cnt == CW'(MAXHOLD - 1));
   assign release_now = done | ~req_held | at_limit;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (winner)
   );

   // One-hot winner to binary index.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (winner[i]) win_idx = W'(i);
      end
   end

   // Arbitration state machine with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         hold_cnt    <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         timeout     <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|winner) begin
                  grant       <= winner;
                  grant_idx   <= win_idx;
                  grant_valid <= 1'b1;
                  hold_cnt    <= '0;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (release_now) begin
                  ptr     <= ptr_after;
                  // Limit-only release: done or an abort suppresses the pulse.
                  timeout <= at_limit & ~done & req_held;
                  if (|winner) begin
                     grant     <= winner;
                     grant_idx <= win_idx;
                     hold_cnt  <= '0;
                  end else begin
                     grant       <= '0;
                     grant_idx   <= '0;
                     grant_valid <= 1'b0;
                     state       <= IDLE;
                  end
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_lock_arb.sv
// Bench for rr_lock_arb: two instances (no hold limit, hold limit 5) share
// stimulus; each is compared every cycle with its own behavioural model.
module tb_rr_lock_arb;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = '0;
   logic       done = 1'b0;

   logic [3:0] grant_a, grant_b;
   logic       valid_a, valid_b;
   logic [1:0] idx_a, idx_b;
   logic       timeout_a, timeout_b;

   int errors = 0;
   int checks = 0;

   // Behavioural model per instance: holder index (-1 = none), pointer,
   // cycles held, pending timeout pulse.
   int m_g[2];
   int m_ptr[2];
   int m_cnt[2];
   bit m_to[2];
   int mh[2] = '{0, 5};

   always #5 clk = ~clk;

   rr_lock_arb #(.N(4), .MAXHOLD(0)) u_nolim (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .grant(grant_a), .grant_valid(valid_a), .grant_idx(idx_a), .timeout(timeout_a)
   );

   rr_lock_arb #(.N(4), .MAXHOLD(5)) u_lim (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .grant(grant_b), .grant_valid(valid_b), .grant_idx(idx_b), .timeout(timeout_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int search(input int start);
      for (int k = 0; k < 4; k++) begin
         if (req[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_g[i] = -1; m_ptr[i] = 0; m_cnt[i] = 0; m_to[i] = 1'b0;
      end
   endfunction

   // Advance one instance's model by one clock edge using the current inputs.
   function automatic void model_step(input int i);
      bit lim, still;
      m_to[i] = 1'b0;
      if (m_g[i] < 0) begin
         m_g[i]   = search(m_ptr[i]);
         m_cnt[i] = 0;
      end else begin
         still = req[m_g[i]];
         lim   = (mh[i] > 0) && (m_cnt[i] == mh[i] - 1);
         if (done || !still || lim) begin
            m_to[i]  = lim && !done && still;
            m_ptr[i] = (m_g[i] + 1) % 4;
            m_g[i]   = search(m_ptr[i]);
            m_cnt[i] = 0;
         end else begin
            m_cnt[i]++;
         end
      end
   endfunction

   task automatic check_models(input string ph);
      logic [3:0] g, eg;
      logic [1:0] ix;
      logic       v, t;
      for (int i = 0; i < 2; i++) begin
         g  = (i == 0) ? grant_a : grant_b;
         ix = (i == 0) ? idx_a : idx_b;
         v  = (i == 0) ? valid_a : valid_b;
         t  = (i == 0) ? timeout_a : timeout_b;
         eg = (m_g[i] < 0) ? 4'b0000 : 4'(1 << m_g[i]);
         chk($sformatf("%s inst%0d grant", ph, i), 32'(g), 32'(eg));
         chk($sformatf("%s inst%0d idx", ph, i), 32'(ix), (m_g[i] < 0) ? 32'd0 : 32'(m_g[i]));
         chk($sformatf("%s inst%0d valid", ph, i), 32'(v), (m_g[i] < 0) ? 32'd0 : 32'd1);
         chk($sformatf("%s inst%0d timeout", ph, i), 32'(t), 32'(m_to[i]));
      end
   endtask

   task automatic step(input string ph);
      for (int i = 0; i < 2; i++) model_step(i);
      @(posedge clk);
      #1;
      check_models(ph);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      done  = 1'b0;
      model_reset();
      #1;
      check_models("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] exp_seq [5];
      model_reset();

      // Single request, then done; the pointer moves past requester 2.
      apply_reset();
      req = 4'b0100;
      step("single");
      chk("single grant", 32'(grant_a), 32'h4);
      chk("single idx", 32'(idx_a), 32'd2);
      step("single");
      step("single");
      chk("single held", 32'(grant_a), 32'h4);
      done = 1'b1; req = 4'b0000;
      step("single");
      chk("single release", 32'(grant_a), 32'h0);
      chk("single valid", 32'(valid_a), 32'd0);
      done = 1'b0; req = 4'b1111;
      step("single");
      chk("single ptr3", 32'(grant_a), 32'h8);

      // Round-robin with done every cycle: no gaps.
      apply_reset();
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      req = 4'b1111; done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step("rr");
         chk($sformatf("rr seq%0d", k), 32'(grant_a), 32'(exp_seq[k]));
      end
      done = 1'b0;

      // Lock: other requesters toggle while the holder keeps its grant.
      apply_reset();
      req = 4'b0001;
      step("lock");
      chk("lock first", 32'(grant_a), 32'h1);
      for (int k = 0; k < 10; k++) begin
         req = {3'($urandom), 1'b1};
         step("lock");
         chk($sformatf("lock cyc%0d", k), 32'(grant_a), 32'h1);
      end

      // Abort: holder drops its request, grant moves with no timeout.
      apply_reset();
      req = 4'b0010;
      step("abort");
      chk("abort first", 32'(grant_a), 32'h2);
      req = 4'b1000;
      step("abort");
      chk("abort next", 32'(grant_a), 32'h8);
      chk("abort timeout", 32'(timeout_a), 32'd0);

      // Timeout on the limited instance, then done wins in the limit cycle.
      apply_reset();
      req = 4'b0011;
      step("tmo");
      chk("tmo first", 32'(grant_b), 32'h1);
      for (int k = 0; k < 4; k++) begin
         step("tmo");
         chk($sformatf("tmo hold%0d", k), 32'(grant_b), 32'h1);
         chk($sformatf("tmo quiet%0d", k), 32'(timeout_b), 32'd0);
      end
      step("tmo");
      chk("tmo next", 32'(grant_b), 32'h2);
      chk("tmo pulse", 32'(timeout_b), 32'd1);
      step("tmo");
      chk("tmo pulse end", 32'(timeout_b), 32'd0);
      step("tmo");
      step("tmo");
      step("tmo");
      done = 1'b1;
      step("tmo");
      chk("tmo done wins", 32'(timeout_b), 32'd0);
      chk("tmo done grant", 32'(grant_b), 32'h1);
      done = 1'b0;

      // Reset mid-hold drops the grant before the next edge.
      apply_reset();
      req = 4'b0100;
      step("rstmid");
      chk("rstmid grant", 32'(grant_a), 32'h4);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("rstmid drop", 32'(grant_a), 32'h0);
      chk("rstmid valid", 32'(valid_a), 32'd0);
      req = 4'b1111;
      #1;
      reset = 1'b0;
      step("rstmid");
      chk("rstmid first", 32'(grant_a), 32'h1);

      // Random traffic against the models.
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         req  = 4'($urandom);
         done = ($urandom_range(0, 3) == 0);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
